// File: rtl/score_keeper_bcd_if.sv
// Score engine bus: game events in, BCD score and status out.
interface score_keeper_bcd_if #(
    parameter int DIGITS   = 4,
    parameter int N_ENM    = 4,
    parameter int HPW      = 7,
    parameter int BOSS_HPW = 10
);
    logic                    gamestart;
    logic                    shot_reimu;
    logic                    shot_enm;
    logic                    shot_boss;
    logic [N_ENM*HPW-1:0]    enmhp;
    logic [BOSS_HPW-1:0]     bosshp;
    logic [DIGITS*4-1:0]     score;
    logic [DIGITS*4-1:0]     hi_score;
    logic                    busy;
    logic                    saturated;
    logic                    new_high;

    // Game side: drives events, observes score.
    modport master (
        output gamestart, shot_reimu, shot_enm, shot_boss, enmhp, bosshp,
        input  score, hi_score, busy, saturated, new_high
    );

    // Score engine side.
    modport slave (
        input  gamestart, shot_reimu, shot_enm, shot_boss, enmhp, bosshp,
        output score, hi_score, busy, saturated, new_high
    );
endinterface

// File: rtl/score_keeper_bcd.sv
// BCD score engine: kill/hit detection, per-type pending award counters,
// one prioritised award per cycle, saturating score and persistent hi-score.
module score_keeper_bcd #(
    parameter int                  DIGITS        = 4,
    parameter int                  N_ENM         = 4,
    parameter int                  HPW           = 7,
    parameter int                  BOSS_HPW      = 10,
    parameter int                  CNTW          = 4,
    parameter logic [DIGITS*4-1:0] PTS_HIT_ENM   = 16'h0001,
    parameter logic [DIGITS*4-1:0] PTS_HIT_BOSS  = 16'h0002,
    parameter logic [DIGITS*4-1:0] PTS_KILL_ENM  = 16'h0100,
    parameter logic [DIGITS*4-1:0] PTS_KILL_BOSS = 16'h1000,
    parameter bit                  CLEAR_ON_HIT  = 1'b1
) (
    input  logic               clk22,
    input  logic               rst_n,
    score_keeper_bcd_if.slave  bus
);
    localparam int              SW     = DIGITS * 4;
    localparam int              CMAX   = (2 ** CNTW) - 1;
    localparam logic [SW-1:0]   ALL9   = {DIGITS{4'h9}};

    // Saturating counter step: add events, remove the serviced one, clamp.
    function automatic logic [CNTW-1:0] cnt_next(input logic [CNTW-1:0] c,
                                                 input int inc,
                                                 input logic dec);
        int v;
        v = int'(c) + inc - (dec ? 1 : 0);
        if (v > CMAX) v = CMAX;
        return CNTW'(v);
    endfunction

    // Per-digit decimal add; MSB of the result is the carry out of the top digit.
    function automatic logic [SW:0] bcd_add(input logic [SW-1:0] a,
                                            input logic [SW-1:0] b);
        logic [SW-1:0] s;
        logic          c;
        logic [4:0]    d;
        s = '0;
        c = 1'b0;
        for (int k = 0; k < DIGITS; k++) begin
            d = {1'b0, a[k*4 +: 4]} + {1'b0, b[k*4 +: 4]} + {4'b0, c};
            if (d > 5'd9) begin
                d = d - 5'd10;
                c = 1'b1;
            end else begin
                c = 1'b0;
            end
            s[k*4 +: 4] = d[3:0];
        end
        return {c, s};
    endfunction

    logic [N_ENM-1:0] r_arm;
    logic             r_boss_arm;
    logic [CNTW-1:0]  r_c_kb, r_c_ke, r_c_hb, r_c_he;
    logic [SW-1:0]    r_score, r_hi;
    logic             r_sat, r_new_high;

    logic [N_ENM-1:0] w_hp_nz;
    logic [N_ENM-1:0] w_kill;
    int               w_nkill;
    logic             w_boss_nz, w_boss_kill;
    logic [3:0]       w_dec;
    logic [SW-1:0]    w_pts;
    logic [SW:0]      w_sum;
    logic             w_clr;
    logic [CNTW-1:0]  w_c_kb_nxt, w_c_ke_nxt, w_c_hb_nxt, w_c_he_nxt;

    // Per-enemy alive flags from the packed HP bus.
    always_comb begin
        for (int i = 0; i < N_ENM; i++) w_hp_nz[i] = |bus.enmhp[i*HPW +: HPW];
    end

    assign w_kill      = ~w_hp_nz & r_arm;
    assign w_boss_nz   = |bus.bosshp;
    assign w_boss_kill = ~w_boss_nz & r_boss_arm;
    assign w_clr       = bus.gamestart | (CLEAR_ON_HIT & bus.shot_reimu);

    // Number of enemies killed on this edge.
    always_comb begin
        w_nkill = 0;
        for (int i = 0; i < N_ENM; i++) if (w_kill[i]) w_nkill++;
    end

    // Fixed-priority service pick on current counters: kb > ke > hb > he.
    always_comb begin
        w_dec = 4'b0000;
        w_pts = '0;
        if (r_c_kb != '0) begin
            w_dec[0] = 1'b1;
            w_pts    = PTS_KILL_BOSS;
        end else if (r_c_ke != '0) begin
            w_dec[1] = 1'b1;
            w_pts    = PTS_KILL_ENM;
        end else if (r_c_hb != '0) begin
            w_dec[2] = 1'b1;
            w_pts    = PTS_HIT_BOSS;
        end else if (r_c_he != '0) begin
            w_dec[3] = 1'b1;
            w_pts    = PTS_HIT_ENM;
        end
    end

    assign w_sum      = bcd_add(r_score, w_pts);
    assign w_c_kb_nxt = cnt_next(r_c_kb, w_boss_kill ? 1 : 0, w_dec[0]);
    assign w_c_ke_nxt = cnt_next(r_c_ke, w_nkill, w_dec[1]);
    assign w_c_hb_nxt = cnt_next(r_c_hb, bus.shot_boss ? 1 : 0, w_dec[2]);
    assign w_c_he_nxt = cnt_next(r_c_he, bus.shot_enm ? 1 : 0, w_dec[3]);

    // Arm bits follow "HP was non-zero last edge"; a kill is alive->zero.
    always_ff @(posedge clk22 or negedge rst_n) begin
        if (!rst_n) begin
            r_arm      <= '0;
            r_boss_arm <= 1'b0;
        end else if (bus.gamestart) begin
            r_arm      <= '0;
            r_boss_arm <= 1'b0;
        end else begin
            r_arm      <= w_hp_nz;
            r_boss_arm <= w_boss_nz;
        end
    end

    // Pending counters and score; a clear drops same-cycle events too.
    always_ff @(posedge clk22 or negedge rst_n) begin
        if (!rst_n) begin
            r_c_kb  <= '0;
            r_c_ke  <= '0;
            r_c_hb  <= '0;
            r_c_he  <= '0;
            r_score <= '0;
            r_sat   <= 1'b0;
        end else if (w_clr) begin
            r_c_kb  <= '0;
            r_c_ke  <= '0;
            r_c_hb  <= '0;
            r_c_he  <= '0;
            r_score <= '0;
            r_sat   <= 1'b0;
        end else begin
            r_c_kb <= w_c_kb_nxt;
            r_c_ke <= w_c_ke_nxt;
            r_c_hb <= w_c_hb_nxt;
            r_c_he <= w_c_he_nxt;
            // Once clamped, awards are still consumed but leave the score alone.
            if ((|w_dec) && !r_sat) begin
                if (w_sum[SW]) begin
                    r_score <= ALL9;
                    r_sat   <= 1'b1;
                end else begin
                    r_score <= w_sum[SW-1:0];
                end
            end
        end
    end

    // Hi-score trails the score by one edge; only rst_n wipes it.
    always_ff @(posedge clk22 or negedge rst_n) begin
        if (!rst_n) begin
            r_hi       <= '0;
            r_new_high <= 1'b0;
        end else begin
            if (r_score > r_hi) r_hi <= r_score;
            if (bus.gamestart)         r_new_high <= 1'b0;
            else if (r_score > r_hi)   r_new_high <= 1'b1;
        end
    end

    assign bus.score     = r_score;
    assign bus.hi_score  = r_hi;
    assign bus.saturated = r_sat;
    assign bus.new_high  = r_new_high;
    assign bus.busy      = (r_c_kb != '0) | (r_c_ke != '0) |
                           (r_c_hb != '0) | (r_c_he != '0);
endmodule

// File: tb/tb_score_keeper_bcd.sv
// Bench for score_keeper_bcd: directed scenarios plus a randomized run
// against a decimal-integer reference model.
module tb_score_keeper_bcd;
    logic clk22 = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad   = 0;

    score_keeper_bcd_if #(.DIGITS(4), .N_ENM(4), .HPW(7), .BOSS_HPW(10)) bus ();

    score_keeper_bcd dut (
        .clk22 (clk22),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk22 = ~clk22;

    // Reference model: plain integers, index 0 kb, 1 ke, 2 hb, 3 he.
    int m_score, m_hi;
    bit m_sat, m_nh;
    int m_c[4];
    bit m_arm[4];
    bit m_barm;
    int pts[4] = '{1000, 100, 2, 1};

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        int t;
        r = '0;
        t = v;
        for (int k = 0; k < 4; k++) begin
            r[k*4 +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic bit m_busy();
        return (m_c[0] + m_c[1] + m_c[2] + m_c[3]) != 0;
    endfunction

    function automatic void model_reset();
        m_score = 0; m_hi = 0; m_sat = 0; m_nh = 0; m_barm = 0;
        for (int k = 0; k < 4; k++) begin m_c[k] = 0; m_arm[k] = 0; end
    endfunction

    // Advance the model by one clock edge using the currently driven inputs.
    function automatic void model_edge();
        int inc[4];
        int sel;
        int kills;
        int v;
        if (m_score > m_hi) begin m_hi = m_score; m_nh = 1; end
        if (bus.gamestart) begin
            m_score = 0; m_sat = 0; m_nh = 0; m_barm = 0;
            for (int k = 0; k < 4; k++) begin m_c[k] = 0; m_arm[k] = 0; end
            return;
        end
        if (bus.shot_reimu) begin
            m_score = 0; m_sat = 0;
            for (int k = 0; k < 4; k++) m_c[k] = 0;
            for (int i = 0; i < 4; i++) m_arm[i] = (bus.enmhp[i*7 +: 7] != 0);
            m_barm = (bus.bosshp != 0);
            return;
        end
        kills = 0;
        for (int i = 0; i < 4; i++) begin
            if (bus.enmhp[i*7 +: 7] == 0 && m_arm[i]) kills++;
            m_arm[i] = (bus.enmhp[i*7 +: 7] != 0);
        end
        inc[0] = (bus.bosshp == 0 && m_barm) ? 1 : 0;
        m_barm = (bus.bosshp != 0);
        inc[1] = kills;
        inc[2] = bus.shot_boss ? 1 : 0;
        inc[3] = bus.shot_enm ? 1 : 0;
        sel = -1;
        for (int k = 0; k < 4; k++) if (sel < 0 && m_c[k] > 0) sel = k;
        if (sel >= 0 && !m_sat) begin
            if (m_score + pts[sel] > 9999) begin m_score = 9999; m_sat = 1; end
            else m_score = m_score + pts[sel];
        end
        for (int k = 0; k < 4; k++) begin
            v = m_c[k] + inc[k] - ((k == sel) ? 1 : 0);
            if (v > 15) v = 15;
            m_c[k] = v;
        end
    endfunction

    task automatic tick();
        model_edge();
        @(posedge clk22);
        #1;
    endtask

    task automatic idle();
        bus.gamestart = 0; bus.shot_reimu = 0; bus.shot_enm = 0; bus.shot_boss = 0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        #2;
        rst_n = 1'b1;
    endtask

    task automatic gamestart();
        bus.gamestart = 1; tick(); bus.gamestart = 0;
    endtask

    task automatic test_reset();
        idle(); bus.enmhp = '0; bus.bosshp = '0;
        rst_n = 1'b0;
        model_reset();
        #12;
        total++; if (bus.score !== 16'h0000) begin bad++; $display("FAIL reset_score got=%h exp=0000", bus.score); end
        total++; if (bus.hi_score !== 16'h0000) begin bad++; $display("FAIL reset_hi got=%h exp=0000", bus.hi_score); end
        total++; if ({bus.busy, bus.saturated, bus.new_high} !== 3'b000) begin bad++;
            $display("FAIL reset_flags got=%b exp=000", {bus.busy, bus.saturated, bus.new_high}); end
        rst_n = 1'b1;
    endtask

    task automatic test_single_hit();
        bus.shot_enm = 1; tick(); bus.shot_enm = 0;
        total++; if (bus.score !== 16'h0000 || bus.busy !== 1'b1) begin bad++;
            $display("FAIL hit_edge1 got=%h/%b exp=0000/1", bus.score, bus.busy); end
        tick();
        total++; if (bus.score !== 16'h0001 || bus.busy !== 1'b0) begin bad++;
            $display("FAIL hit_edge2 got=%h/%b exp=0001/0", bus.score, bus.busy); end
    endtask

    task automatic test_multi_kill();
        gamestart();
        bus.enmhp = {4{7'd5}}; tick();
        bus.enmhp = '0; tick();
        total++; if (bus.score !== 16'h0000 || bus.busy !== 1'b1) begin bad++;
            $display("FAIL kill4_queued got=%h/%b exp=0000/1", bus.score, bus.busy); end
        for (int k = 1; k <= 4; k++) begin
            tick();
            total++; if (bus.score !== to_bcd(100 * k)) begin bad++;
                $display("FAIL kill4_step%0d got=%h exp=%h", k, bus.score, to_bcd(100 * k)); end
        end
        tick(); tick();
        total++; if (bus.score !== 16'h0400 || bus.busy !== 1'b0) begin bad++;
            $display("FAIL kill4_hold got=%h/%b exp=0400/0", bus.score, bus.busy); end
    endtask

    task automatic test_saturate();
        gamestart();
        for (int n = 0; n < 9; n++) begin
            bus.bosshp = 10'd1; tick();
            bus.bosshp = 10'd0; tick();
        end
        bus.enmhp = {4{7'd5}}; tick(); bus.enmhp = '0; tick();
        bus.enmhp = {4{7'd5}}; tick(); bus.enmhp = '0; tick();
        bus.enmhp = 28'd5;     tick(); bus.enmhp = '0; tick();
        repeat (6) tick();
        bus.shot_boss = 1; repeat (25) tick(); bus.shot_boss = 0;
        repeat (4) tick();
        total++; if (bus.score !== 16'h9950 || bus.saturated !== 1'b0) begin bad++;
            $display("FAIL preload got=%h/%b exp=9950/0", bus.score, bus.saturated); end
        bus.bosshp = 10'd1; tick(); bus.bosshp = 10'd0; tick(); tick();
        total++; if (bus.score !== 16'h9999 || bus.saturated !== 1'b1) begin bad++;
            $display("FAIL sat_clamp got=%h/%b exp=9999/1", bus.score, bus.saturated); end
        bus.shot_enm = 1; tick(); bus.shot_enm = 0; tick(); tick();
        total++; if (bus.score !== 16'h9999 || bus.busy !== 1'b0) begin bad++;
            $display("FAIL sat_hold got=%h/%b exp=9999/0", bus.score, bus.busy); end
    endtask

    task automatic test_priority();
        gamestart();
        bus.bosshp = 10'd1; bus.enmhp = 28'd5; tick();
        bus.bosshp = 10'd0; bus.enmhp = '0; bus.shot_enm = 1; tick(); bus.shot_enm = 0;
        tick();
        total++; if (bus.score !== 16'h1000) begin bad++; $display("FAIL prio_kb got=%h exp=1000", bus.score); end
        tick();
        total++; if (bus.score !== 16'h1100) begin bad++; $display("FAIL prio_ke got=%h exp=1100", bus.score); end
        tick();
        total++; if (bus.score !== 16'h1101 || bus.busy !== 1'b0) begin bad++;
            $display("FAIL prio_he got=%h/%b exp=1101/0", bus.score, bus.busy); end
    endtask

    task automatic test_hi_score();
        @(negedge clk22); do_reset(); @(posedge clk22); #1;
        bus.enmhp = {7'd0, 7'd5, 7'd5, 7'd5}; tick(); bus.enmhp = '0; tick();
        repeat (3) tick();
        total++; if (bus.score !== 16'h0300) begin bad++; $display("FAIL hi_reach got=%h exp=0300", bus.score); end
        tick();
        total++; if (bus.hi_score !== 16'h0300 || bus.new_high !== 1'b1) begin bad++;
            $display("FAIL hi_follow got=%h/%b exp=0300/1", bus.hi_score, bus.new_high); end
        bus.shot_reimu = 1; tick(); bus.shot_reimu = 0;
        total++; if (bus.score !== 16'h0000 || bus.hi_score !== 16'h0300) begin bad++;
            $display("FAIL reimu_clear got=%h/%h exp=0000/0300", bus.score, bus.hi_score); end
        bus.enmhp = {7'd0, 7'd0, 7'd5, 7'd5}; tick(); bus.enmhp = '0; tick();
        tick(); tick(); tick();
        total++; if (bus.score !== 16'h0200 || bus.hi_score !== 16'h0300) begin bad++;
            $display("FAIL hi_keep got=%h/%h exp=0200/0300", bus.score, bus.hi_score); end
        gamestart();
        total++; if (bus.new_high !== 1'b0 || bus.hi_score !== 16'h0300) begin bad++;
            $display("FAIL gs_newhigh got=%b/%h exp=0/0300", bus.new_high, bus.hi_score); end
    endtask

    task automatic test_reset_mid();
        gamestart();
        bus.enmhp = {4{7'd5}}; tick(); bus.enmhp = '0; tick();
        total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL mid_busy got=%b exp=1", bus.busy); end
        #3;
        rst_n = 1'b0;
        model_reset();
        #1;
        total++; if ({bus.score, bus.hi_score, bus.busy, bus.saturated, bus.new_high} !== 35'd0) begin bad++;
            $display("FAIL async_rst got=%h/%h/%b%b%b exp=0", bus.score, bus.hi_score,
                     bus.busy, bus.saturated, bus.new_high); end
        #2;
        rst_n = 1'b1;
        repeat (3) tick();
        total++; if (bus.score !== 16'h0000 || bus.busy !== 1'b0) begin bad++;
            $display("FAIL dead_after_rst got=%h/%b exp=0000/0", bus.score, bus.busy); end
    endtask

    task automatic test_random();
        gamestart();
        for (int n = 0; n < 400; n++) begin
            bus.shot_enm   = ($urandom % 3) == 0;
            bus.shot_boss  = ($urandom % 4) == 0;
            bus.shot_reimu = ($urandom % 64) == 0;
            bus.gamestart  = ($urandom % 128) == 0;
            for (int i = 0; i < 4; i++)
                bus.enmhp[i*7 +: 7] = ($urandom % 2) ? 7'($urandom_range(1, 127)) : 7'd0;
            bus.bosshp = ($urandom % 3) ? 10'd0 : 10'($urandom_range(1, 1023));
            tick();
            total++; if (bus.score !== to_bcd(m_score)) begin bad++;
                $display("FAIL rnd_score cyc=%0d got=%h exp=%h", n, bus.score, to_bcd(m_score)); end
            total++; if (bus.hi_score !== to_bcd(m_hi)) begin bad++;
                $display("FAIL rnd_hi cyc=%0d got=%h exp=%h", n, bus.hi_score, to_bcd(m_hi)); end
            total++; if ({bus.busy, bus.saturated, bus.new_high} !== {m_busy(), m_sat, m_nh}) begin bad++;
                $display("FAIL rnd_flags cyc=%0d got=%b exp=%b", n,
                         {bus.busy, bus.saturated, bus.new_high}, {m_busy(), m_sat, m_nh}); end
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_single_hit();
        test_multi_kill();
        test_saturate();
        test_priority();
        test_hi_score();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
